// File: rtl/pattern_sequencer_if.sv
// Note-fetch handshake and pattern-memory bus between the sequencer and its
// channel controller / pattern memory. The master side is the sequencer.
interface pattern_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              i_enable;
    logic              o_valid;
    logic              o_busy;
    logic [ADDR_W-1:0] o_rom_addr;
    logic              o_rom_rd;
    logic [15:0]       i_rom_data;
    logic [5:0]        o_pitch;
    logic [7:0]        o_duration;
    logic              o_rest;
    logic              o_halted;

    modport master (
        input  i_enable, i_rom_data,
        output o_valid, o_busy, o_rom_addr, o_rom_rd,
               o_pitch, o_duration, o_rest, o_halted
    );

    modport slave (
        output i_enable, i_rom_data,
        input  o_valid, o_busy, o_rom_addr, o_rom_rd,
               o_pitch, o_duration, o_rest, o_halted
    );
endinterface

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: fetches one 16-bit note entry per enable request.
// Optional PATTERN_LOOP_EN: end marker reloads LOOP_ADDR instead of halting.
module pattern_sequencer #(
    parameter int ADDR_W = 8
`ifdef PATTERN_LOOP_EN
    ,
    parameter logic [ADDR_W-1:0] LOOP_ADDR = '0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pattern_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [5:0]        pitch_reg, pitch_next;
    logic [7:0]        duration_reg, duration_next;
    logic              rest_reg, rest_next;
    logic              halted_reg, halted_next;
    logic              valid_reg, rd_reg, busy_reg;
`ifdef PATTERN_LOOP_EN
    logic              marker_reg, marker_next;
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        pitch_next    = pitch_reg;
        duration_next = duration_reg;
        rest_next     = rest_reg;
        halted_next   = halted_reg;
`ifdef PATTERN_LOOP_EN
        marker_next   = marker_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_enable) begin
                    // Once halted, a request just re-presents the halt note.
                    if (halted_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_READ;
`ifdef PATTERN_LOOP_EN
                        marker_next = 1'b0;
`endif
                    end
                end
            end
            ST_READ: begin
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!bus.i_rom_data[15]) begin
                    rest_next     = bus.i_rom_data[14];
                    pitch_next    = bus.i_rom_data[13:8];
                    duration_next = bus.i_rom_data[7:0];
                    addr_next     = addr_reg + ADDR_W'(1);
                    state_next    = ST_DONE;
`ifdef PATTERN_LOOP_EN
                    marker_next   = 1'b0;
`endif
                end else begin
`ifdef PATTERN_LOOP_EN
                    // A marker straight after a reload means the loop body is empty.
                    if (marker_reg) begin
                        rest_next     = 1'b1;
                        pitch_next    = 6'd0;
                        duration_next = 8'hFF;
                        halted_next   = 1'b1;
                        state_next    = ST_DONE;
                    end else begin
                        marker_next = 1'b1;
                        addr_next   = LOOP_ADDR;
                        state_next  = ST_READ;
                    end
`else
                    rest_next     = 1'b1;
                    pitch_next    = 6'd0;
                    duration_next = 8'hFF;
                    halted_next   = 1'b1;
                    state_next    = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            pitch_reg    <= 6'd0;
            duration_reg <= 8'd0;
            rest_reg     <= 1'b1;
            halted_reg   <= 1'b0;
            valid_reg    <= 1'b0;
            rd_reg       <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef PATTERN_LOOP_EN
            marker_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            pitch_reg    <= pitch_next;
            duration_reg <= duration_next;
            rest_reg     <= rest_next;
            halted_reg   <= halted_next;
            valid_reg    <= (state_next == ST_DONE);
            rd_reg       <= (state_next == ST_READ);
            busy_reg     <= (state_next != ST_IDLE);
`ifdef PATTERN_LOOP_EN
            marker_reg   <= marker_next;
`endif
        end
    end

    assign bus.o_valid    = valid_reg;
    assign bus.o_busy     = busy_reg;
    assign bus.o_rom_addr = addr_reg;
    assign bus.o_rom_rd   = rd_reg;
    assign bus.o_pitch    = pitch_reg;
    assign bus.o_duration = duration_reg;
    assign bus.o_rest     = rest_reg;
    assign bus.o_halted   = halted_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed self-checking bench for pattern_sequencer with a one-cycle-latency
// pattern memory model.
module tb_pattern_sequencer;
    localparam int ADDR_W = 8;
    localparam logic [26:0] RST_OUTS = {1'b0, 1'b0, 1'b0, 8'h00, 6'h00, 8'h00, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_count = 0;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    pattern_sequencer_if #(.ADDR_W(ADDR_W)) seq_if ();

    pattern_sequencer #(.ADDR_W(ADDR_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (seq_if.master)
    );

    always @(posedge clk) begin
        if (seq_if.o_rom_rd === 1'b1) begin
            seq_if.i_rom_data <= mem[seq_if.o_rom_addr];
            rd_count <= rd_count + 1;
        end
    end

    function automatic logic [26:0] outs();
        return {seq_if.o_valid, seq_if.o_busy, seq_if.o_rom_rd, seq_if.o_rom_addr,
                seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest, seq_if.o_halted};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        seq_if.i_enable = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses enable from the current negedge and returns at the o_valid cycle.
    task automatic fetch_quiet();
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        seq_if.i_enable = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (outs() !== RST_OUTS) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want %h", outs(), RST_OUTS);
        end
        $display("reset: outputs %h", outs());
    endtask

    task automatic test_single_note();
        do_reset();
        mem[0] = 16'h0A10;
        repeat (3) @(negedge clk);
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        n_cmp++;
        if ({seq_if.o_rom_rd, seq_if.o_rom_addr, seq_if.o_busy, seq_if.o_valid} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rd: got rd=%b addr=%h busy=%b valid=%b want rd=1 addr=00 busy=1 valid=0",
                     seq_if.o_rom_rd, seq_if.o_rom_addr, seq_if.o_busy, seq_if.o_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({seq_if.o_rom_rd, seq_if.o_busy, seq_if.o_valid} !== 3'b010) begin
            n_bad++;
            $display("FAIL single_capture: got rd/busy/valid=%b want 010",
                     {seq_if.o_rom_rd, seq_if.o_busy, seq_if.o_valid});
        end
        @(negedge clk);
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest, seq_if.o_rom_addr}
            !== {1'b1, 6'd10, 8'd16, 1'b0, 8'h01}) begin
            n_bad++;
            $display("FAIL single_note: got valid=%b pitch=%0d dur=%0d rest=%b addr=%h want 1/10/16/0/01",
                     seq_if.o_valid, seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest, seq_if.o_rom_addr);
        end
        $display("single: pitch=%0d dur=%0d rest=%b", seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest);
        @(negedge clk);
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_busy, seq_if.o_pitch, seq_if.o_duration} !== {1'b0, 1'b0, 6'd10, 8'd16}) begin
            n_bad++;
            $display("FAIL single_hold: got valid=%b busy=%b pitch=%0d dur=%0d want 0/0/10/16",
                     seq_if.o_valid, seq_if.o_busy, seq_if.o_pitch, seq_if.o_duration);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp_note [0:2];
        int k = 0;
        int rd_before;
        logic exp_v;
        exp_note[0] = {6'd1, 8'd5, 1'b0};
        exp_note[1] = {6'd2, 8'd3, 1'b1};
        exp_note[2] = {6'd63, 8'd128, 1'b0};
        do_reset();
        mem[0] = 16'h0105;
        mem[1] = 16'h4203;
        mem[2] = 16'h3F80;
        rd_before = rd_count;
        // Enable held high: ignored while busy, accepted in each IDLE cycle.
        seq_if.i_enable = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 9) seq_if.i_enable = 1'b0;
            exp_v = (i == 3 || i == 7 || i == 11);
            n_cmp++;
            if (seq_if.o_valid !== exp_v) begin
                n_bad++;
                $display("FAIL b2b_valid_c%0d: got %b want %b", i, seq_if.o_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if ({seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest} !== exp_note[k]) begin
                    n_bad++;
                    $display("FAIL b2b_note%0d: got %h want %h", k,
                             {seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest}, exp_note[k]);
                end
                $display("b2b note %0d: pitch=%0d dur=%0d rest=%b", k,
                         seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest);
                k++;
            end
        end
        n_cmp++;
        if (rd_count - rd_before !== 3) begin
            n_bad++;
            $display("FAIL b2b_rd_count: got %0d want 3", rd_count - rd_before);
        end
    endtask

    task automatic test_wrap();
        int seen = 0;
        int cyc = 0;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = {2'b00, 6'(i), 8'(i)};
        seq_if.i_enable = 1'b1;
        while (seen < 256 && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            if (seq_if.o_valid === 1'b1) begin
                seen++;
                if (seen == 255) begin
                    n_cmp++;
                    if (seq_if.o_rom_addr !== 8'hFF) begin
                        n_bad++;
                        $display("FAIL wrap_addr_255: got %h want ff", seq_if.o_rom_addr);
                    end
                end
                if (seen == 256) begin
                    seq_if.i_enable = 1'b0;
                    n_cmp++;
                    if ({seq_if.o_rom_addr, seq_if.o_pitch, seq_if.o_duration} !== {8'h00, 6'd63, 8'hFF}) begin
                        n_bad++;
                        $display("FAIL wrap_to_zero: got addr=%h pitch=%0d dur=%0d want 00/63/255",
                                 seq_if.o_rom_addr, seq_if.o_pitch, seq_if.o_duration);
                    end
                    $display("wrap: note 256 pitch=%0d dur=%0d addr=%h",
                             seq_if.o_pitch, seq_if.o_duration, seq_if.o_rom_addr);
                end
            end
        end
        seq_if.i_enable = 1'b0;
        n_cmp++;
        if (seen != 256) begin
            n_bad++;
            $display("FAIL wrap_timeout: got %0d notes want 256", seen);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int pulses = 0;
        do_reset();
        mem[0] = 16'h0A10;
        mem[1] = 16'h0B20;
        fetch_quiet();
        @(negedge clk);
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs() !== RST_OUTS) begin
            n_bad++;
            $display("FAIL midfetch_async: got %h want %h", outs(), RST_OUTS);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (seq_if.o_valid !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL midfetch_no_valid: got %0d pulses want 0", pulses);
        end
        n_cmp++;
        if (outs() !== RST_OUTS) begin
            n_bad++;
            $display("FAIL midfetch_after: got %h want %h", outs(), RST_OUTS);
        end
        $display("midfetch: outputs %h after release", outs());
    endtask

`ifndef PATTERN_LOOP_EN
    task automatic test_halt_noloop();
        int rd_before;
        do_reset();
        mem[0] = 16'h0A10;
        mem[1] = 16'h8000;
        fetch_quiet();
        @(negedge clk);
        fetch_quiet();
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_rest, seq_if.o_pitch, seq_if.o_duration, seq_if.o_halted, seq_if.o_rom_addr}
            !== {1'b1, 1'b1, 6'd0, 8'hFF, 1'b1, 8'h01}) begin
            n_bad++;
            $display("FAIL halt_note: got valid=%b rest=%b pitch=%0d dur=%h halted=%b addr=%h want 1/1/0/ff/1/01",
                     seq_if.o_valid, seq_if.o_rest, seq_if.o_pitch, seq_if.o_duration,
                     seq_if.o_halted, seq_if.o_rom_addr);
        end
        $display("halt: rest=%b dur=%h halted=%b", seq_if.o_rest, seq_if.o_duration, seq_if.o_halted);
        repeat (2) @(negedge clk);
        rd_before = rd_count;
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_busy, seq_if.o_rom_rd} !== 3'b110) begin
            n_bad++;
            $display("FAIL halt_repeat: got valid/busy/rd=%b want 110",
                     {seq_if.o_valid, seq_if.o_busy, seq_if.o_rom_rd});
        end
        @(negedge clk);
        n_cmp++;
        if ({rd_count - rd_before, seq_if.o_rom_addr, seq_if.o_halted} !== {32'd0, 8'h01, 1'b1}) begin
            n_bad++;
            $display("FAIL halt_frozen: got rds=%0d addr=%h halted=%b want 0/01/1",
                     rd_count - rd_before, seq_if.o_rom_addr, seq_if.o_halted);
        end
    endtask
`else
    task automatic test_loop_reload();
        do_reset();
        mem[0] = 16'h0A10;
        mem[1] = 16'h8000;
        fetch_quiet();
        @(negedge clk);
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        n_cmp++;
        if ({seq_if.o_rom_rd, seq_if.o_rom_addr} !== {1'b1, 8'h01}) begin
            n_bad++;
            $display("FAIL loop_rd1: got rd=%b addr=%h want 1/01", seq_if.o_rom_rd, seq_if.o_rom_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({seq_if.o_rom_rd, seq_if.o_rom_addr, seq_if.o_valid} !== {1'b1, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL loop_rd2: got rd=%b addr=%h valid=%b want 1/00/0",
                     seq_if.o_rom_rd, seq_if.o_rom_addr, seq_if.o_valid);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest, seq_if.o_rom_addr, seq_if.o_halted}
            !== {1'b1, 6'd10, 8'd16, 1'b0, 8'h01, 1'b0}) begin
            n_bad++;
            $display("FAIL loop_note: got valid=%b pitch=%0d dur=%0d rest=%b addr=%h halted=%b want 1/10/16/0/01/0",
                     seq_if.o_valid, seq_if.o_pitch, seq_if.o_duration, seq_if.o_rest,
                     seq_if.o_rom_addr, seq_if.o_halted);
        end
        $display("loop: reloaded note pitch=%0d dur=%0d", seq_if.o_pitch, seq_if.o_duration);
    endtask

    task automatic test_loop_halt();
        int rd_before;
        do_reset();
        mem[0] = 16'h8000;
        rd_before = rd_count;
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_rest, seq_if.o_pitch, seq_if.o_duration, seq_if.o_halted, rd_count - rd_before}
            !== {1'b1, 1'b1, 6'd0, 8'hFF, 1'b1, 32'd2}) begin
            n_bad++;
            $display("FAIL loop_halt_note: got valid=%b rest=%b pitch=%0d dur=%h halted=%b rds=%0d want 1/1/0/ff/1/2",
                     seq_if.o_valid, seq_if.o_rest, seq_if.o_pitch, seq_if.o_duration,
                     seq_if.o_halted, rd_count - rd_before);
        end
        $display("loop halt: rest=%b dur=%h halted=%b", seq_if.o_rest, seq_if.o_duration, seq_if.o_halted);
        repeat (2) @(negedge clk);
        rd_before = rd_count;
        seq_if.i_enable = 1'b1;
        @(negedge clk);
        seq_if.i_enable = 1'b0;
        n_cmp++;
        if ({seq_if.o_valid, seq_if.o_rom_rd} !== 2'b10) begin
            n_bad++;
            $display("FAIL loop_halt_repeat: got valid/rd=%b want 10", {seq_if.o_valid, seq_if.o_rom_rd});
        end
        @(negedge clk);
        n_cmp++;
        if (rd_count - rd_before !== 0) begin
            n_bad++;
            $display("FAIL loop_halt_no_rd: got %0d reads want 0", rd_count - rd_before);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        seq_if.i_enable = 1'b0;
        test_reset();
        test_single_note();
        test_back_to_back();
        test_wrap();
        test_reset_mid_fetch();
`ifndef PATTERN_LOOP_EN
        test_halt_noloop();
`else
        test_loop_reload();
        test_loop_halt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
